iir_biquad_seq: RTL
===================

Name: iir_biquad_seq

Overview:
- Parametrised, self-sequenced successor to the second-order filter datapath.
- Computes one Direct-Form-II biquad per input sample in signed fixed point, using a single multiply-accumulate path driven by an internal FSM instead of external enables.
- Time-multiplexes CHANNELS independent channels, each with its own delay state. All channels share one coefficient set, latched per sample.
- Adds a valid/ready input handshake, a done pulse, saturation and overflow warnings, and a state clear.

Parameters:
- WIDTH, 16, total bits of samples, coefficients and delay state (two's complement).
- FRAC, 8, fractional bits; 1.0 = 2^FRAC.
- CHANNELS, 2, number of independent channel states (>=1).
- CH_W, max(1, clog2(CHANNELS)), width of the channel index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- uk  in  WIDTH  input sample, signed.
- ch_in  in  CH_W  channel of the offered sample.
- a1, a2, b0, b1, b2  in  WIDTH each  signed Q coefficients.
- state_clr  in  1  zero all channel delay state.
- clr_ovf  in  1  clear the sticky overflow flag.
- yk  out  WIDTH  last output sample, signed.
- out_ch  out  CH_W  channel of yk.
- listo  out  1  one-cycle pulse: yk/out_ch updated.
- sat_warn  out  1  one-cycle pulse with listo if any saturation occurred in that sample.
- ovf_sticky  out  1  set on any saturation; held until clr_ovf or reset.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high; port names clk and reset.
- Reset values: yk=0, out_ch=0, listo=0, sat_warn=0, ovf_sticky=0, all f1[ch]/f2[ch]=0, FSM=IDLE.
- Equations, per channel c:
  - f = sat(u - a1*f1[c] - a2*f2[c])
  - y = sat(b0*f + b1*f1[c] + b2*f2[c])
  - then f2[c] <= f1[c], f1[c] <= f.
- Product rule:
  - Each product is the full 2*WIDTH signed result, arithmetic-shifted right by FRAC (floor toward -inf).
  - Accumulator is 2*WIDTH-FRAC+2 bits, so no internal wrap.
- sat(): clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Applied once to f and once to y.
- FSM states: IDLE, F1, F2, FSAT, Y0, Y1, Y2, WB.
  - IDLE: in_ready=1 unless state_clr=1.
    - in_valid & in_ready latches uk, ch_in and all 5 coefficients; acc<=sext(uk); go to F1.
  - F1: acc -= a1*f1.
  - F2: acc -= a2*f2.
  - FSAT: f_new <= sat(acc); acc <= 0; record saturation.
  - Y0: acc += b0*f_new.
  - Y1: acc += b1*f1.
  - Y2: acc += b2*f2.
  - WB: yk <= sat(acc); out_ch <= ch; shift channel state; listo<=1; sat_warn <= (FSAT or WB saturated); go to IDLE.
- Timing:
  - Handshake in cycle 0; listo is high in cycle 8, one cycle only.
  - in_ready=0 in cycles 1-7; max throughput is 1 sample / 8 cycles.
  - Next handshake is allowed in cycle 8.
- yk and out_ch hold their value between listo pulses.
- Latched coefficients make changes on a1..b2 during busy cycles have no effect on the sample in flight.
- Only the selected channel's state changes; other channels are untouched.
- ch_in >= CHANNELS: sample is accepted and processed as channel 0.
- state_clr:
  - Honoured only in IDLE; zeroes all f1/f2 in that cycle.
  - When simultaneous with in_valid, the clear wins and no handshake occurs (in_ready=0).
  - Ignored while busy.
- ovf_sticky: set in WB when sat_warn; if clr_ovf and a new saturation coincide, set wins.
- Reset mid-operation: aborts the sample; no listo; every register returns to its reset value.

Test Plan:
- WIDTH=16, FRAC=8 throughout.
- Pass-through (b0=256, others 0): uk=100, ch0 -> listo exactly 8 cycles after handshake, yk=100, out_ch=0; in_ready=0 for cycles 1-7.
- Recursion (a1=-128, a2=0, b0=256, others 0): ch0 inputs 256, 0, 0 -> yk=256, 128, 64.
- Channel isolation, same coefficients: interleave ch0 256, 0, 0 with ch1 0, 0, 0 -> ch0 yields 256, 128, 64; ch1 yields 0, 0, 0.
- Saturation (b0=512): uk=20000 -> yk=32767, sat_warn=1, ovf_sticky=1 until clr_ovf; uk=-20000 -> yk=-32768.
- Truncation (b0=128): uk=-3 -> yk=-2; uk=3 -> yk=1.
- Control: reset asserted in cycle 4 -> no listo, yk=0, next impulse gives a fresh 256, 128 response. state_clr with in_valid in IDLE -> no accept, all state cleared. in_valid held while busy -> accepted only at cycle 8.

Source files
------------

// File: rtl/iir_biquad_seq.sv
`timescale 1ns/1ps
// Multi-channel Direct-Form-II biquad with one shared multiply-accumulate path,
// sequenced by an eight-state FSM (one sample in, one result 8 cycles later).
module iir_biquad_seq #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int CHANNELS = 2,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] uk,
  input  logic [CH_W-1:0]  ch_in,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic             state_clr,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] yk,
  output logic [CH_W-1:0]  out_ch,
  output logic             listo,
  output logic             sat_warn,
  output logic             ovf_sticky,
  output logic [2:0]       fsm_state
);

  localparam int ACC_W = 2*WIDTH - FRAC + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, F1, F2, FSAT, Y0, Y1, Y2, WB} state_t;

  state_t state, state_nx;

  logic signed [WIDTH-1:0] c_a1, c_a2, c_b0, c_b1, c_b2;
  logic signed [WIDTH-1:0] f_new;
  logic signed [WIDTH-1:0] f1_mem [CHANNELS];
  logic signed [WIDTH-1:0] f2_mem [CHANNELS];
  logic [CH_W-1:0]         ch;
  logic signed [ACC_W-1:0] acc;
  logic                    f_sat;

  logic signed [WIDTH-1:0]   cur_f1, cur_f2, mul_a, mul_b, sat_val;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic                      sat_hit, accept;

  assign fsm_state = state;
  assign cur_f1    = f1_mem[ch];
  assign cur_f2    = f2_mem[ch];
  // Handshake: a sample transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready is only high in IDLE and only when no clear is requested.
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mul_a    = c_b0;
    mul_b    = f_new;
    case (state)
      IDLE: begin
        in_ready = ~state_clr;
        if (in_valid && !state_clr) state_nx = F1;
      end
      F1:   begin mul_a = c_a1; mul_b = cur_f1; state_nx = F2;   end
      F2:   begin mul_a = c_a2; mul_b = cur_f2; state_nx = FSAT; end
      FSAT: state_nx = Y0;
      Y0:   begin mul_a = c_b0; mul_b = f_new;  state_nx = Y1;   end
      Y1:   begin mul_a = c_b1; mul_b = cur_f1; state_nx = Y2;   end
      Y2:   begin mul_a = c_b2; mul_b = cur_f2; state_nx = WB;   end
      WB:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Full-precision product, floored by the arithmetic shift, then widened.
  assign prod     = mul_a * mul_b;
  assign prod_ext = ACC_W'(prod >>> FRAC);

  always_comb begin
    sat_hit = 1'b0;
    sat_val = acc[WIDTH-1:0];
    if (acc > SAT_MAX) begin
      sat_hit = 1'b1;
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (acc < SAT_MIN) begin
      sat_hit = 1'b1;
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      f_new      <= '0;
      f_sat      <= 1'b0;
      ch         <= '0;
      c_a1       <= '0;
      c_a2       <= '0;
      c_b0       <= '0;
      c_b1       <= '0;
      c_b2       <= '0;
      yk         <= '0;
      out_ch     <= '0;
      listo      <= 1'b0;
      sat_warn   <= 1'b0;
      ovf_sticky <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        f1_mem[i] <= '0;
        f2_mem[i] <= '0;
      end
    end else begin
      listo    <= 1'b0;
      sat_warn <= 1'b0;
      if (clr_ovf) ovf_sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (state_clr) begin
            for (int i = 0; i < CHANNELS; i++) begin
              f1_mem[i] <= '0;
              f2_mem[i] <= '0;
            end
          end else if (accept) begin
            c_a1  <= a1;
            c_a2  <= a2;
            c_b0  <= b0;
            c_b1  <= b1;
            c_b2  <= b2;
            ch    <= (int'(ch_in) >= CHANNELS) ? '0 : ch_in;
            acc   <= ACC_W'($signed(uk));
            f_sat <= 1'b0;
          end
        end
        F1, F2: acc <= acc - prod_ext;
        FSAT: begin
          f_new <= sat_val;
          f_sat <= sat_hit;
          acc   <= '0;
        end
        Y0, Y1, Y2: acc <= acc + prod_ext;
        WB: begin
          yk         <= sat_val;
          out_ch     <= ch;
          f2_mem[ch] <= f1_mem[ch];
          f1_mem[ch] <= f_new;
          listo      <= 1'b1;
          sat_warn   <= f_sat | sat_hit;
          // A new saturation overrides a simultaneous clr_ovf.
          if (f_sat | sat_hit) ovf_sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
